// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and constants for the dmem bus responder.
//   dmem_resp_state_t : responder FSM states (IDLE, WAIT, RESP)
//   DMEM_DATA_W       : bus data width
//   DMEM_ERR_DATA     : read data returned for out-of-range reads
//   dmem_lat_load     : wait-counter load value for a given latency
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  localparam int          DMEM_DATA_W   = 16;
  localparam logic [15:0] DMEM_ERR_DATA = 16'hDEAD;

  // The counter is loaded with LATENCY-1 so that WAIT lasts exactly LATENCY
  // cycles. A latency of 0 never enters WAIT, so its load value is irrelevant.
  function automatic logic [3:0] dmem_lat_load(input int lat);
    logic [3:0] v;
    v = 4'd0;
    if (lat > 0) begin
      v = 4'(lat - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// dmem bus bundle between an initiator (master) and the responder (slave).
//   Data_req      : request qualifier (master -> slave)
//   Data_rd       : 1 = read, 0 = write (master -> slave)
//   Data_addr     : word address (master -> slave)
//   Data_din      : write data (master -> slave)
//   Data_dout     : read data (slave -> master)
//   complete_data : one-cycle completion pulse (slave -> master)
//   Data_err      : range error, only when DMEM_RANGE_CHECK_EN is defined
// Optional feature macro: DMEM_RANGE_CHECK_EN
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                   Data_req;
  logic                   Data_rd;
  logic [DMEM_DATA_W-1:0] Data_addr;
  logic [DMEM_DATA_W-1:0] Data_din;
  logic [DMEM_DATA_W-1:0] Data_dout;
  logic                   complete_data;
`ifdef DMEM_RANGE_CHECK_EN
  logic                   Data_err;

  modport master (
    output Data_req, Data_rd, Data_addr, Data_din,
    input  Data_dout, complete_data, Data_err
  );

  modport slave (
    input  Data_req, Data_rd, Data_addr, Data_din,
    output Data_dout, complete_data, Data_err
  );
`else
  modport master (
    output Data_req, Data_rd, Data_addr, Data_din,
    input  Data_dout, complete_data
  );

  modport slave (
    input  Data_req, Data_rd, Data_addr, Data_din,
    output Data_dout, complete_data
  );
`endif

endinterface

// File: rtl/dmem_resp_ram.sv
// -----------------------------------------------------------------------------
// dmem_resp_ram
// Single-port synchronous RAM, DEPTH x 16, one-cycle registered read,
// contents not reset (maps onto block RAM).
//   clock : rising-edge clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after addr is presented
// -----------------------------------------------------------------------------
module dmem_resp_ram
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory slave on the dmem bus. Accepts one read or write per request in
// IDLE, waits LATENCY cycles, then completes with a one-cycle complete_data
// pulse in RESP. Read data is held on Data_dout until the next read or reset.
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : dmem_responder_if.slave (Data_req/rd/addr/din in,
//            Data_dout/complete_data[/Data_err] out)
// Parameters: DEPTH (words, power of two), LATENCY (0..15), ADDR_BITS.
// Optional feature macro: DMEM_RANGE_CHECK_EN -- flags and suppresses
// accesses with Data_addr >= DEPTH; otherwise addresses wrap modulo DEPTH.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam logic [3:0] LAT_LOAD = dmem_lat_load(LATENCY);

  dmem_resp_state_t       r_state;
  dmem_resp_state_t       w_state_next;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_next;

  // Captured request; the bus is ignored once the request is accepted.
  logic                   r_rd;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DMEM_DATA_W-1:0] r_din;
  logic                   r_oor;

  logic [DMEM_DATA_W-1:0] r_dout;

  logic                   w_accept;
  logic                   w_oor_in;
  logic                   w_ram_we;
  logic [ADDR_BITS-1:0]   w_ram_addr;
  logic [DMEM_DATA_W-1:0] w_ram_rdata;
  logic [DMEM_DATA_W-1:0] w_resp_data;
  logic                   w_in_resp;

  assign w_accept  = (r_state == IDLE) && bus.Data_req;
  assign w_in_resp = (r_state == RESP);

`ifdef DMEM_RANGE_CHECK_EN
  // Widen by one bit so DEPTH=65536 compares correctly.
  assign w_oor_in = ({1'b0, bus.Data_addr} >= 17'(DEPTH));
`else
  assign w_oor_in = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register and counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.Data_req) begin
          if (LATENCY > 0) begin
            w_state_next = WAIT;
            w_cnt_next   = LAT_LOAD;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request capture and read-data holding register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
      r_oor  <= 1'b0;
      r_dout <= '0;
    end else begin
      if (w_accept) begin
        r_rd   <= bus.Data_rd;
        r_addr <= bus.Data_addr[ADDR_BITS-1:0];
        r_din  <= bus.Data_din;
        r_oor  <= w_oor_in;
      end
      if (w_in_resp && r_rd) begin
        r_dout <= w_resp_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // RAM: the read must be launched the cycle before RESP. With LATENCY=0
  // that cycle is the accepting IDLE cycle, when the request registers are
  // not yet loaded, so IDLE presents the live bus address instead.
  // -------------------------------------------------------------------------
  assign w_ram_addr = (r_state == IDLE) ? bus.Data_addr[ADDR_BITS-1:0] : r_addr;
  // Gating with reset drops a write whose RESP edge coincides with reset.
  assign w_ram_we   = w_in_resp && !r_rd && !r_oor && !reset;

  dmem_resp_ram #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clock (clock),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (r_din),
    .rdata (w_ram_rdata)
  );

  assign w_resp_data = r_oor ? DMEM_ERR_DATA : w_ram_rdata;

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.Data_dout     = (w_in_resp && r_rd) ? w_resp_data : r_dout;
  assign bus.complete_data = w_in_resp;
`ifdef DMEM_RANGE_CHECK_EN
  assign bus.Data_err      = w_in_resp && r_oor;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder: one instance with LATENCY=2 and one with
// LATENCY=0, both DEPTH=1024. Range-check vectors run only when
// DMEM_RANGE_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut2 (
    .clock (clk),
    .reset (rst),
    .bus   (bus2.slave)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
    .clock (clk),
    .reset (rst),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic rd,
                       input logic [15:0] addr, input logic [15:0] din);
    if (sel == 0) begin
      bus0.Data_req = req; bus0.Data_rd = rd; bus0.Data_addr = addr; bus0.Data_din = din;
    end else begin
      bus2.Data_req = req; bus2.Data_rd = rd; bus2.Data_addr = addr; bus2.Data_din = din;
    end
  endtask

  function automatic logic get_cmpl(input int sel);
    return (sel == 0) ? bus0.complete_data : bus2.complete_data;
  endfunction

  function automatic logic [15:0] get_dout(input int sel);
    return (sel == 0) ? bus0.Data_dout : bus2.Data_dout;
  endfunction

  function automatic logic get_err(input int sel);
`ifdef DMEM_RANGE_CHECK_EN
    return (sel == 0) ? bus0.Data_err : bus2.Data_err;
`else
    return (sel < 0);
`endif
  endfunction

  // One bus transaction starting from IDLE. lat counts clock edges from the
  // accepting edge (inclusive) to the edge after which complete_data is seen.
  task automatic txn(input int sel, input logic rd, input logic [15:0] addr,
                     input logic [15:0] din, input logic scramble,
                     output logic [15:0] dout, output logic err, output int lat);
    logic done;
    drive(sel, 1'b1, rd, addr, din);
    @(posedge clk); #1;
    lat = 1;
    if (scramble) drive(sel, 1'b0, rd, ~addr, ~din);
    else          drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    done = get_cmpl(sel);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      done = get_cmpl(sel);
    end
    dout = get_dout(sel);
    err  = get_err(sel);
    $display("txn dut%0d %s addr=%h din=%h dout=%h err=%b lat=%0d",
             sel, rd ? "RD" : "WR", addr, din, dout, err, lat);
    @(posedge clk); #1;
  endtask

  logic [15:0] dout;
  logic        err;
  int          lat;
  int          edges;
  logic [15:0] exp_b2b [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_b2b[0] = 16'h1111; exp_b2b[1] = 16'h2222; exp_b2b[2] = 16'h3333;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmpl2", 32'(bus2.complete_data), 32'h0);
    check("rst_dout2", 32'(bus2.Data_dout), 32'h0);
    check("rst_cmpl0", 32'(bus0.complete_data), 32'h0);
    check("rst_dout0", 32'(bus0.Data_dout), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then read back, LATENCY=2
    txn(2, 1'b0, 16'h0010, 16'hA5C3, 1'b0, dout, err, lat);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_dout_held", 32'(dout), 32'h0000);
    txn(2, 1'b1, 16'h0010, 16'h0000, 1'b0, dout, err, lat);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data", 32'(dout), 32'hA5C3);
    check("rd_hold", 32'(bus2.Data_dout), 32'hA5C3);
    txn(2, 1'b0, 16'h0020, 16'h1234, 1'b0, dout, err, lat);
    check("wr2_dout_held", 32'(dout), 32'hA5C3);
    txn(2, 1'b1, 16'h0020, 16'h0000, 1'b0, dout, err, lat);
    check("rd2_data", 32'(dout), 32'h1234);

`ifndef DMEM_RANGE_CHECK_EN
    // Address wrap modulo DEPTH
    txn(2, 1'b0, 16'h0405, 16'hBEEF, 1'b0, dout, err, lat);
    txn(2, 1'b1, 16'h0005, 16'h0000, 1'b0, dout, err, lat);
    check("wrap_data", 32'(dout), 32'hBEEF);
`endif

    // Bus changes after acceptance must not affect the captured write
    txn(2, 1'b0, 16'h03CF, 16'h1111, 1'b0, dout, err, lat);
    txn(2, 1'b0, 16'h0030, 16'h7777, 1'b1, dout, err, lat);
    txn(2, 1'b1, 16'h0030, 16'h0000, 1'b0, dout, err, lat);
    check("midchg_orig", 32'(dout), 32'h7777);
    txn(2, 1'b1, 16'h03CF, 16'h0000, 1'b0, dout, err, lat);
    check("midchg_other", 32'(dout), 32'h1111);

    // Reset held for 3 cycles mid-WAIT
    drive(2, 1'b1, 1'b1, 16'h0010, 16'h0000);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstwait_cmpl", 32'(bus2.complete_data), 32'h0);
    end
    check("rstwait_dout", 32'(bus2.Data_dout), 32'h0);
    rst = 1'b0;
    $display("txn dut2 reset abort during WAIT");
    txn(2, 1'b1, 16'h0010, 16'h0000, 1'b0, dout, err, lat);
    check("postrst_lat", 32'(lat), 32'd3);
    check("postrst_data", 32'(dout), 32'hA5C3);

    // Reset coinciding with RESP drops the pending write
    drive(2, 1'b1, 1'b0, 16'h0010, 16'h5555);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("rstresp_in_resp", 32'(bus2.complete_data), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstresp_cmpl", 32'(bus2.complete_data), 32'h0);
    rst = 1'b0;
    $display("txn dut2 reset abort during RESP write");
    txn(2, 1'b1, 16'h0010, 16'h0000, 1'b0, dout, err, lat);
    check("rstresp_kept", 32'(dout), 32'hA5C3);

    // LATENCY=0: preload, then back-to-back reads with Data_req held high
    txn(0, 1'b0, 16'h0001, 16'h1111, 1'b0, dout, err, lat);
    check("l0_wr_lat", 32'(lat), 32'd1);
    txn(0, 1'b0, 16'h0002, 16'h2222, 1'b0, dout, err, lat);
    txn(0, 1'b0, 16'h0003, 16'h3333, 1'b0, dout, err, lat);
    drive(0, 1'b1, 1'b1, 16'h0001, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      edges = 0;
      do begin
        @(posedge clk); #1;
        edges++;
      end while (!bus0.complete_data && edges < 10);
      $display("txn dut0 RD b2b addr=%h dout=%h edges=%0d", 16'(k + 1), bus0.Data_dout, edges);
      check("b2b_data", 32'(bus0.Data_dout), 32'(exp_b2b[k]));
      check("b2b_gap", 32'(edges), (k == 0) ? 32'd1 : 32'd2);
      drive(0, 1'b1, 1'b1, 16'(k + 2), 16'h0000);
    end
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;

`ifdef DMEM_RANGE_CHECK_EN
    txn(2, 1'b0, 16'h0000, 16'h4242, 1'b0, dout, err, lat);
    check("rc_wr0_err", 32'(err), 32'h0);
    txn(2, 1'b1, 16'h0400, 16'h0000, 1'b0, dout, err, lat);
    check("rc_rd_err", 32'(err), 32'h1);
    check("rc_rd_dead", 32'(dout), 32'hDEAD);
    check("rc_rd_lat", 32'(lat), 32'd3);
    check("rc_err_idle", 32'(bus2.Data_err), 32'h0);
    txn(2, 1'b0, 16'h0400, 16'h9999, 1'b0, dout, err, lat);
    check("rc_wr_err", 32'(err), 32'h1);
    txn(2, 1'b1, 16'h0000, 16'h0000, 1'b0, dout, err, lat);
    check("rc_rd0_data", 32'(dout), 32'h4242);
    check("rc_rd0_err", 32'(err), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
